pc_sequencer: RTL and testbench

Program-counter sequencer for the 12-bit processor. It owns the instruction address and steps it through straight-line code. It redirects the address on taken jumps (`jdne`/`jine`) and taken `beq`, using the destination produced by the jump-calculation logic. It also handles start, stall and halt, and exposes a run-cycle counter for profiling.

---
 rtl/pc_sequencer.sv | 113 +++++++++++
 tb/tb_pc_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, jump/beq redirect, stall, halt and a run-cycle counter.
// Optional macro PC_JUMP_FLUSH_EN inserts one FLUSH bubble after every taken redirect.
module pc_sequencer #(
    parameter int IA_WIDTH  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 stall_i,
    input  logic                 halt_i,
    input  logic                 jump_en_i,
    input  logic                 beq_i,
    input  logic                 zero_i,
    input  logic [IA_WIDTH-1:0]  jump_dest_i,
    output logic [IA_WIDTH-1:0]  pc_o,
    output logic                 fetch_valid_o,
    output logic                 flush_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] cycle_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [IA_WIDTH-1:0]  pc_q, pc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 fv_q, fv_d;
    logic                 flush_q, flush_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 redirect;

    assign redirect = jump_en_i | (beq_i & zero_i);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            fv_q    <= 1'b0;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            fv_q    <= fv_d;
            flush_q <= flush_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // busy_q mirrors "state is RUN or FLUSH", so it gates the counter directly
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (busy_q && !(&cnt_q))
            cnt_d = cnt_q + CNT_WIDTH'(1);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (stall_i) begin
                    state_d = S_RUN;
                end else if (halt_i) begin
                    state_d = S_DONE;
                end else if (redirect) begin
                    pc_d = jump_dest_i;
`ifdef PC_JUMP_FLUSH_EN
                    state_d = S_FLUSH;
`endif
                end else begin
                    pc_d = pc_q + IA_WIDTH'(1);
                end
            end
`ifdef PC_JUMP_FLUSH_EN
            S_FLUSH: state_d = S_RUN;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it
    always_comb begin
        fv_d    = (state_d == S_RUN);
`ifdef PC_JUMP_FLUSH_EN
        flush_d = (state_d == S_FLUSH);
        busy_d  = (state_d == S_RUN) || (state_d == S_FLUSH);
`else
        flush_d = 1'b0;
        busy_d  = (state_d == S_RUN);
`endif
        done_d  = (state_d == S_DONE);
    end

    assign pc_o          = pc_q;
    assign fetch_valid_o = fv_q;
    assign flush_o       = flush_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign cycle_cnt_o   = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver queues the expected state per cycle,
// a monitor pops and compares one entry after every rising edge.
module tb_pc_sequencer;
    localparam int IA = 8;
    localparam int CW = 5;
    localparam logic [1:0] I = 2'd0, R = 2'd1, F = 2'd2, D = 2'd3;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1, start_i = 1'b0, stall_i = 1'b0, halt_i = 1'b0;
    logic          jump_en_i = 1'b0, beq_i = 1'b0, zero_i = 1'b0;
    logic [IA-1:0] jump_dest_i = '0;
    logic [IA-1:0] pc_o;
    logic          fetch_valid_o, flush_o, busy_o, done_o;
    logic [CW-1:0] cycle_cnt_o;

    pc_sequencer #(.IA_WIDTH(IA), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .stall_i(stall_i),
        .halt_i(halt_i), .jump_en_i(jump_en_i), .beq_i(beq_i), .zero_i(zero_i),
        .jump_dest_i(jump_dest_i), .pc_o(pc_o), .fetch_valid_o(fetch_valid_o),
        .flush_o(flush_o), .busy_o(busy_o), .done_o(done_o), .cycle_cnt_o(cycle_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [IA-1:0] pc;
        logic [1:0]    st;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nmis = 0;

    // monitor: one expectation per edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                logic [IA+CW+3:0] act, req;
                e = q.pop_front();
                act = {pc_o, fetch_valid_o, flush_o, busy_o, done_o, cycle_cnt_o};
                req = {e.pc, e.st == R, e.st == F, (e.st == R) || (e.st == F), e.st == D, e.cnt};
                nvec++;
                if (act !== req) begin
                    nmis++;
                    $display("FAIL %s: got pc=%h fv=%b fl=%b busy=%b done=%b cnt=%0d, want pc=%h fv=%b fl=%b busy=%b done=%b cnt=%0d",
                             e.tag, pc_o, fetch_valid_o, flush_o, busy_o, done_o, cycle_cnt_o,
                             req[IA+CW+3:CW+4], req[CW+3], req[CW+2], req[CW+1], req[CW], req[CW-1:0]);
                end
            end
        end
    end

    task automatic cyc(input string tag, input logic r, s, st, h, j, b, z,
                       input logic [IA-1:0] d, input logic [IA-1:0] epc,
                       input logic [1:0] est, input int ecnt);
        exp_t e;
        @(negedge clk);
        reset_i = r; start_i = s; stall_i = st; halt_i = h;
        jump_en_i = j; beq_i = b; zero_i = z; jump_dest_i = d;
        e.tag = tag; e.pc = epc; e.st = est; e.cnt = CW'(ecnt);
        q.push_back(e);
    endtask

    task automatic nop(input string tag, input logic [IA-1:0] epc, input logic [1:0] est, input int ecnt);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0, 8'h00, epc, est, ecnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        // reset, straight-line run, halt at 5
        cyc("reset", 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, I, 0);
        nop("idle_hold", 8'h00, I, 0);
        cyc("start", 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, R, 0);
        for (int i = 1; i <= 5; i++) nop("seq", IA'(i), R, i);
        cyc("halt5", 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h05, D, 6);
        nop("done_hold", 8'h05, D, 6);

        // jump at 7 to 2, then beq not-taken / taken
        cyc("restart", 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, R, 0);
        for (int i = 1; i <= 7; i++) nop("seq2", IA'(i), R, i);
`ifdef PC_JUMP_FLUSH_EN
        cyc("jump7", 0, 0, 0, 0, 1, 0, 0, 8'h02, 8'h02, F, 8);
`else
        cyc("jump7", 0, 0, 0, 0, 1, 0, 0, 8'h02, 8'h02, R, 8);
`endif
        cyc("post_jump", 0, 0, 1, 1, 1, 0, 0, 8'h09, 8'h02, R, 9);
        cyc("beq_nz", 0, 0, 0, 0, 0, 1, 0, 8'h0E, 8'h03, R, 10);
`ifdef PC_JUMP_FLUSH_EN
        cyc("beq_z", 0, 0, 0, 0, 0, 1, 1, 8'h0E, 8'h0E, F, 11);
        nop("beq_after", 8'h0E, R, 12);
        cyc("jmp_beq", 0, 0, 0, 0, 1, 1, 1, 8'h20, 8'h20, F, 13);
        nop("jmp_beq_after", 8'h20, R, 14);
        cyc("halt_a", 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h20, D, 15);
`else
        cyc("beq_z", 0, 0, 0, 0, 0, 1, 1, 8'h0E, 8'h0E, R, 11);
        nop("beq_after", 8'h0F, R, 12);
        cyc("jmp_beq", 0, 0, 0, 0, 1, 1, 1, 8'h20, 8'h20, R, 13);
        nop("jmp_beq_after", 8'h21, R, 14);
        cyc("halt_a", 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h21, D, 15);
`endif

        // stall beats halt and jump
        cyc("restart3", 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, R, 0);
        for (int i = 1; i <= 4; i++) nop("seq3", IA'(i), R, i);
        for (int i = 0; i < 3; i++) cyc("stall", 0, 0, 1, 1, 1, 0, 0, 8'h09, 8'h04, R, 5 + i);
        cyc("halt_after_stall", 0, 0, 0, 1, 1, 0, 0, 8'h09, 8'h04, D, 8);

        // wrap 0xFE -> 0xFF -> 0x00
        cyc("restart4", 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, R, 0);
`ifdef PC_JUMP_FLUSH_EN
        cyc("jump_fe", 0, 0, 0, 0, 1, 0, 0, 8'hFE, 8'hFE, F, 1);
        nop("fe", 8'hFE, R, 2);
        c = 2;
`else
        cyc("jump_fe", 0, 0, 0, 0, 1, 0, 0, 8'hFE, 8'hFE, R, 1);
        c = 1;
`endif
        nop("ff", 8'hFF, R, c + 1);
        nop("wrap00", 8'h00, R, c + 2);

        // counter saturates at 31 while stalled
        for (int i = 1; i <= 32; i++)
            cyc("sat", 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, R, (c + 2 + i > 31) ? 31 : c + 2 + i);

        // reset right after a redirect (mid-FLUSH when enabled), then mid-run start ignored
`ifdef PC_JUMP_FLUSH_EN
        cyc("jump40", 0, 0, 0, 0, 1, 0, 0, 8'h40, 8'h40, F, 31);
`else
        cyc("jump40", 0, 0, 0, 0, 1, 0, 0, 8'h40, 8'h40, R, 31);
`endif
        cyc("reset_mid", 1, 0, 0, 0, 1, 0, 0, 8'h40, 8'h00, I, 0);
        nop("idle_after_rst", 8'h00, I, 0);
        cyc("start5", 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, R, 0);
        cyc("start_in_run", 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h01, R, 1);
        cyc("start_in_run2", 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h02, R, 2);
        cyc("halt_b", 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h02, D, 3);
        nop("done_hold2", 8'h02, D, 3);

        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            nmis++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
